nfsr_keystream_gen: RTL and testbench

//  Parametrised successor of the fixed 24-bit NFSR: seed-loaded shift register with selectable

---
 rtl/nfsr_keystream_pkg.sv | 15 +
 rtl/nfsr_core.sv | 45 ++++
 rtl/nfsr_keystream_gen.sv | 131 +++++++++++++
 tb/tb_nfsr_keystream_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfsr_keystream_pkg.sv
// Shared definitions for the NFSR keystream generator: FSM encoding and feedback-mode constants.
// Ports: none (package only).
// Imported by nfsr_core and nfsr_keystream_gen.
package nfsr_keystream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } fsm_state_t;

  localparam logic MODE_NFSR = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

endpackage

// File: rtl/nfsr_core.sv
// Purpose : shift-register state with NFSR/LFSR feedback and seed load; one shift per enabled cycle.
// Ports   : clk/rst (sync, active-high), i_load/i_seed (load wins over shift), i_mode (latched mode),
//           i_shift (advance one step), o_state (current register), o_seed_zero (seed is all-zero).
module nfsr_core
  import nfsr_keystream_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAP_A = 1,
  parameter int TAP_B = 3,
  parameter int TAP_C = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_mode,
  input  logic             i_shift,
  output logic [WIDTH-1:0] o_state,
  output logic             o_seed_zero
);

  logic [WIDTH-1:0] r_state;
  logic             w_and_term;
  logic             w_fb;

  assign o_seed_zero = (i_seed == '0);

  // The AND term is what makes the register non-linear; LFSR mode drops it.
  assign w_and_term = (i_mode == MODE_LFSR) ? 1'b0 : (r_state[TAP_B] & r_state[TAP_C]);
  assign w_fb       = r_state[0] ^ r_state[TAP_A] ^ w_and_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
    end else if (i_load) begin
      // All-zero is a fixed point of the feedback, so it is replaced by 1.
      r_state <= o_seed_zero ? WIDTH'(1) : i_seed;
    end else if (i_shift) begin
      r_state <= {w_fb, r_state[WIDTH-1:1]};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/nfsr_keystream_gen.sv
// Purpose : seed-loaded NFSR/LFSR keystream source with warm-up and a valid/ready serial output.
// Ports   : clk/rst (sync, active-high); Par_load/Seed/mode/stream_len start a sequence; shift_en
//           freezes everything when low; Ser_out/ser_valid/ser_ready handshake; Par_out, busy, done, seed_err status.
module nfsr_keystream_gen
  import nfsr_keystream_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int TAP_A  = 1,
  parameter int TAP_B  = 3,
  parameter int TAP_C  = 7,
  parameter int WARMUP = 48,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Par_load,
  input  logic [WIDTH-1:0] Seed,
  input  logic             mode,
  input  logic [LEN_W-1:0] stream_len,
  input  logic             shift_en,
  input  logic             ser_ready,
  output logic             Ser_out,
  output logic             ser_valid,
  output logic [WIDTH-1:0] Par_out,
  output logic             busy,
  output logic             done,
  output logic             seed_err
);

  localparam int              WC_W      = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WC_W-1:0] WARM_INIT = WC_W'(WARMUP);

  fsm_state_t       r_fsm;
  fsm_state_t       w_fsm_nxt;
  logic [WC_W-1:0]  r_warm_cnt;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_mode;
  logic             r_seed_err;
  logic             r_done;

  logic [WIDTH-1:0] w_state;
  logic             w_seed_zero;
  logic             w_in_warm;
  logic             w_in_run;
  logic             w_valid;
  logic             w_xfer;
  logic             w_last;
  logic             w_warm_last;
  logic             w_shift;

  assign w_in_warm   = (r_fsm == ST_WARMUP);
  assign w_in_run    = (r_fsm == ST_RUN);
  assign w_valid     = w_in_run & shift_en;
  assign w_xfer      = w_valid & ser_ready;
  // A zero length means free-run, so the terminal count is never matched.
  assign w_last      = w_xfer & (r_len != '0) & (r_bit_cnt == (r_len - LEN_W'(1)));
  assign w_warm_last = w_in_warm & shift_en & (r_warm_cnt == WC_W'(1));
  assign w_shift     = (w_in_warm & shift_en) | w_xfer;

  nfsr_core #(
    .WIDTH (WIDTH),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B),
    .TAP_C (TAP_C)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_load      (Par_load),
    .i_seed      (Seed),
    .i_mode      (r_mode),
    .i_shift     (w_shift),
    .o_state     (w_state),
    .o_seed_zero (w_seed_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Load outranks warm-up completion and end-of-stream, which aborts a running stream.
  always_comb begin
    w_fsm_nxt = r_fsm;
    if (Par_load) begin
      w_fsm_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
    end else if (w_warm_last) begin
      w_fsm_nxt = ST_RUN;
    end else if (w_last) begin
      w_fsm_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_warm_cnt <= '0;
      r_bit_cnt  <= '0;
      r_len      <= '0;
      r_mode     <= MODE_NFSR;
      r_seed_err <= 1'b0;
      r_done     <= 1'b0;
    end else if (Par_load) begin
      r_warm_cnt <= WARM_INIT;
      r_bit_cnt  <= '0;
      r_len      <= stream_len;
      r_mode     <= mode;
      r_seed_err <= w_seed_zero;
      r_done     <= 1'b0;
    end else begin
      if (w_in_warm & shift_en) begin
        r_warm_cnt <= r_warm_cnt - WC_W'(1);
      end
      // Free-run streams let this wrap without consequence.
      if (w_xfer) begin
        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
      end
      r_done <= w_last;
    end
  end

  assign Ser_out   = w_state[0];
  assign ser_valid = w_valid;
  assign Par_out   = w_state;
  assign busy      = (r_fsm != ST_IDLE);
  assign done      = r_done;
  assign seed_err  = r_seed_err;

endmodule

// File: tb/tb_nfsr_keystream_gen.sv
// Directed bench for nfsr_keystream_gen: three instances (8-bit no warm-up, 8-bit warm-up 7, defaults)
// share stimulus; expected stream entries are queued at load time and popped on each transfer.
module tb_nfsr_keystream_gen;

  typedef struct packed {
    logic [23:0] par;
    logic        ser;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        par_load;
  logic [7:0]  seed8;
  logic [23:0] seed24;
  logic        mode_i;
  logic [15:0] len_i;
  logic        shift_en;
  logic        ser_ready;

  logic        a_ser, a_vld, a_busy, a_done, a_err;
  logic [7:0]  a_par;
  logic        b_ser, b_vld, b_busy, b_done, b_err;
  logic [7:0]  b_par;
  logic        c_ser, c_vld, c_busy, c_done, c_err;
  logic [23:0] c_par;

  int          sel;
  logic        m_ser, m_vld, m_busy, m_done, m_err;
  logic [23:0] m_par;

  int          n_assert = 0;
  int          n_fail   = 0;
  exp_t        q[$];

  always #5 clk = ~clk;

  nfsr_keystream_gen #(.WIDTH(8), .TAP_A(2), .TAP_B(1), .TAP_C(3), .WARMUP(0), .LEN_W(16)) dut_a (
    .clk(clk), .rst(rst), .Par_load(par_load), .Seed(seed8), .mode(mode_i), .stream_len(len_i),
    .shift_en(shift_en), .ser_ready(ser_ready), .Ser_out(a_ser), .ser_valid(a_vld), .Par_out(a_par),
    .busy(a_busy), .done(a_done), .seed_err(a_err));

  nfsr_keystream_gen #(.WIDTH(8), .TAP_A(2), .TAP_B(1), .TAP_C(3), .WARMUP(7), .LEN_W(16)) dut_b (
    .clk(clk), .rst(rst), .Par_load(par_load), .Seed(seed8), .mode(mode_i), .stream_len(len_i),
    .shift_en(shift_en), .ser_ready(ser_ready), .Ser_out(b_ser), .ser_valid(b_vld), .Par_out(b_par),
    .busy(b_busy), .done(b_done), .seed_err(b_err));

  nfsr_keystream_gen dut_c (
    .clk(clk), .rst(rst), .Par_load(par_load), .Seed(seed24), .mode(mode_i), .stream_len(len_i),
    .shift_en(shift_en), .ser_ready(ser_ready), .Ser_out(c_ser), .ser_valid(c_vld), .Par_out(c_par),
    .busy(c_busy), .done(c_done), .seed_err(c_err));

  always_comb begin
    m_ser = a_ser; m_vld = a_vld; m_busy = a_busy; m_done = a_done; m_err = a_err;
    m_par = {16'h0, a_par};
    if (sel == 1) begin
      m_ser = b_ser; m_vld = b_vld; m_busy = b_busy; m_done = b_done; m_err = b_err;
      m_par = {16'h0, b_par};
    end else if (sel == 2) begin
      m_ser = c_ser; m_vld = c_vld; m_busy = c_busy; m_done = c_done; m_err = c_err;
      m_par = c_par;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] step8(input logic [7:0] s, input logic md);
    logic f;
    f = s[0] ^ s[2] ^ (md ? 1'b0 : (s[1] & s[3]));
    return {f, s[7:1]};
  endfunction

  function automatic logic [23:0] step24(input logic [23:0] s, input logic md);
    logic f;
    f = s[0] ^ s[1] ^ (md ? 1'b0 : (s[3] & s[7]));
    return {f, s[23:1]};
  endfunction

  task automatic push_model(input logic [7:0] s0, input logic md, input int n);
    exp_t       e;
    logic [7:0] s;
    s = s0;
    for (int i = 0; i < n; i++) begin
      e.par = {16'h0, s};
      e.ser = s[0];
      q.push_back(e);
      s = step8(s, md);
    end
  endtask

  task automatic push_tab(input logic [7:0] t0, t1, t2, t3, t4, t5, t6, t7, t8, input int n);
    logic [7:0] tab [9];
    exp_t       e;
    tab = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
    for (int i = 0; i < n; i++) begin
      e.par = {16'h0, tab[i]};
      e.ser = tab[i][0];
      q.push_back(e);
    end
  endtask

  // Called and returns at posedge+1. Loads on the next edge.
  task automatic load(input logic [7:0] s8, input logic [23:0] s24, input logic md, input logic [15:0] ln);
    par_load = 1'b1; seed8 = s8; seed24 = s24; mode_i = md; len_i = ln;
    @(posedge clk); #1;
    par_load = 1'b0;
  endtask

  // Pops one queued entry per transfer. After hold_after transfers: 4 cycles ready low, then
  // 2 cycles shift_en low, both with the state expected to hold. Ends by checking the done pulse.
  task automatic drain(input int budget, input int hold_after);
    exp_t e;
    int   xfers = 0;
    int   hold  = 0;
    int   cyc   = 0;
    while (q.size() > 0 && cyc < budget) begin
      if (hold > 0) begin
        ser_ready = (hold > 2) ? 1'b0 : 1'b1;
        shift_en  = (hold > 2) ? 1'b1 : 1'b0;
      end else begin
        ser_ready = 1'b1;
        shift_en  = 1'b1;
      end
      #1;
      if (hold > 0) begin
        chk("hold_par", m_par, q[0].par);
        chk("hold_ser", m_ser, q[0].ser);
        chk("hold_valid", m_vld, (hold > 2));
        hold--;
      end else if (m_vld && ser_ready) begin
        e = q.pop_front();
        chk("stream_par", m_par, e.par);
        chk("stream_ser", m_ser, e.ser);
        xfers++;
        if (xfers == hold_after) hold = 6;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_leftover", q.size(), 0);
    q.delete();
    #1;
    chk("done_pulse", m_done, 1'b1);
    chk("busy_after", m_busy, 1'b0);
    chk("valid_after", m_vld, 1'b0);
    @(posedge clk); #1;
    chk("done_single", m_done, 1'b0);
  endtask

  initial begin
    int          waited;
    logic [7:0]  s8;
    logic [23:0] s24;
    logic        any_zero;
    logic        any_done;

    rst = 1'b1; par_load = 1'b0; seed8 = '0; seed24 = '0; mode_i = 1'b0; len_i = '0;
    shift_en = 1'b1; ser_ready = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_par", m_par, 0);
    chk("rst_ser", m_ser, 0);
    chk("rst_valid", m_vld, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_err", m_err, 0);
    chk("rst_par_c", c_par, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // LFSR stream, length 9
    sel = 0;
    load(8'h01, 24'h0, 1'b1, 16'd9);
    push_tab(8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h82, 8'h41, 9);
    drain(40, -1);

    // NFSR stream, length 3
    load(8'h0B, 24'h0, 1'b0, 16'd3);
    push_tab(8'h0B, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    drain(40, -1);
    chk("nfsr_final_par", m_par, 8'h01);

    // Backpressure and freeze after the first bit
    load(8'h0B, 24'h0, 1'b0, 16'd3);
    push_tab(8'h0B, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    drain(40, 1);

    // Zero seed substitution, sticky flag
    load(8'h00, 24'h0, 1'b1, 16'd9);
    #1;
    chk("zero_err", m_err, 1'b1);
    chk("zero_par", m_par, 8'h01);
    push_tab(8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h82, 8'h41, 9);
    drain(40, -1);
    chk("zero_err_sticky", m_err, 1'b1);

    // Warm-up of 7 on dut_b; dut_a sees the same load and clears its flag
    sel = 1;
    ser_ready = 1'b0; shift_en = 1'b1;
    load(8'h01, 24'h0, 1'b1, 16'd9);
    #1;
    chk("reload_clears_err", a_err, 1'b0);
    chk("warm_busy", m_busy, 1'b1);
    waited = 1;
    while (!m_vld && waited < 100) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("warm_latency", waited, 8);
    s8 = 8'h01;
    for (int i = 0; i < 7; i++) s8 = step8(s8, 1'b1);
    chk("warm_first_par", m_par, s8);
    chk("warm_first_ser", m_ser, s8[0]);
    @(posedge clk); #1;
    push_model(s8, 1'b1, 9);
    drain(40, -1);

    // Abort mid-RUN by reloading (dut_a)
    sel = 0;
    load(8'h01, 24'h0, 1'b1, 16'd9);
    ser_ready = 1'b1; shift_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load(8'h0B, 24'h0, 1'b0, 16'd3);
    #1;
    chk("abort_no_done", m_done, 1'b0);
    chk("abort_par", m_par, 8'h0B);
    chk("abort_busy", m_busy, 1'b1);
    push_tab(8'h0B, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    @(posedge clk); #1;
    // one transfer already happened on the edge above
    void'(q.pop_front());
    drain(40, -1);

    // Reset in the middle of a free-running stream with seed_err set
    load(8'h00, 24'h0, 1'b1, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_par", m_par, 0);
    chk("mid_rst_valid", m_vld, 0);
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_done", m_done, 0);
    chk("mid_rst_err", m_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Default parameters: warm-up 48, free-run, compare against the reference model
    sel = 2;
    ser_ready = 1'b1; shift_en = 1'b1;
    load(8'h00, 24'habcdef, 1'b0, 16'd0);
    waited = 1;
    #1;
    while (!m_vld && waited < 200) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("c_warm_latency", waited, 49);
    @(posedge clk); #1;
    // the transfer on the edge above consumed the first bit
    s24 = 24'habcdef;
    for (int i = 0; i < 49; i++) s24 = step24(s24, 1'b0);
    any_zero = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      #1;
      if (m_par == 24'h0) any_zero = 1'b1;
      if (m_done) any_done = 1'b1;
      chk("c_stream_par", m_par, s24);
      s24 = step24(s24, 1'b0);
      @(posedge clk); #1;
    end
    #1;
    chk("c_never_zero", any_zero, 1'b0);
    chk("c_never_done", any_done, 1'b0);
    chk("c_still_valid", m_vld, 1'b1);
    chk("c_still_busy", m_busy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
